// File: rtl/mul_share_pkg.sv
// Shared widths and the operand record carried through the shared multiplier pipeline.
package mul_share_pkg;

    localparam int unsigned NUM_REQ_DEF     = 4;
    localparam int unsigned A_BITS_DEF      = 8;
    localparam int unsigned B_BITS_DEF      = 8;
    localparam int unsigned C_BITS_DEF      = A_BITS_DEF + B_BITS_DEF;
    localparam int unsigned MUL_LATENCY_DEF = 2;
    localparam int unsigned ID_BITS_DEF     = $clog2(NUM_REQ_DEF);

    // Operand pair plus the tag of the requester that issued it. Field widths track the
    // package defaults, so a width change is made here rather than at instantiation.
    typedef struct packed {
        logic [A_BITS_DEF-1:0]  a;
        logic [B_BITS_DEF-1:0]  b;
        logic [ID_BITS_DEF-1:0] id;
    } req_t;

endpackage

// File: rtl/mul_share_pipe.sv
// Pipelined unsigned multiplier: one operand register stage followed by MUL_LATENCY-1
// product stages. Valid and requester tag travel alongside the product.
(* use_dsp = "no" *)
module mul_share_pipe
    import mul_share_pkg::*;
#(
    parameter int unsigned C_BITS      = C_BITS_DEF,
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cke,
    input  logic                   in_valid_i,
    input  req_t                   in_req_i,
    output logic                   out_valid_o,
    output logic [ID_BITS_DEF-1:0] out_id_o,
    output logic [C_BITS-1:0]      out_c_o
);

    logic [MUL_LATENCY-1:0] vld_q, vld_d;
    req_t                   op_q, op_d;

    // Stage k view of product and tag; index 0 is combinational from the operand register.
    logic [C_BITS-1:0]      prod [MUL_LATENCY];
    logic [ID_BITS_DEF-1:0] tag  [MUL_LATENCY];

    // Valid shifts every enabled cycle; operands load only on issue so they hold otherwise.
    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = in_valid_i;
        for (int k = 1; k < MUL_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
        end
        op_d = op_q;
        if (in_valid_i) begin
            op_d = in_req_i;
        end
    end

    // Operand register and valid chain; reset clears everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            op_q  <= '0;
        end else if (cke) begin
            vld_q <= vld_d;
            op_q  <= op_d;
        end
    end

    assign prod[0] = C_BITS'(op_q.a) * C_BITS'(op_q.b);
    assign tag[0]  = op_q.id;

    for (genvar k = 1; k < MUL_LATENCY; k++) begin : g_stage
        logic [C_BITS-1:0]      prod_q, prod_d;
        logic [ID_BITS_DEF-1:0] tag_q, tag_d;

        // Data advances only behind a valid op, so the last result stays on the bus.
        always_comb begin
            prod_d = prod_q;
            tag_d  = tag_q;
            if (vld_q[k-1]) begin
                prod_d = prod[k-1];
                tag_d  = tag[k-1];
            end
        end

        // Product stage register.
        always_ff @(posedge clk) begin
            if (reset) begin
                prod_q <= '0;
                tag_q  <= '0;
            end else if (cke) begin
                prod_q <= prod_d;
                tag_q  <= tag_d;
            end
        end

        assign prod[k] = prod_q;
        assign tag[k]  = tag_q;
    end

    assign out_valid_o = vld_q[MUL_LATENCY-1];
    assign out_id_o    = tag[MUL_LATENCY-1];
    assign out_c_o     = prod[MUL_LATENCY-1];

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler feeding one shared pipelined multiplier from NUM_REQ requesters.
// Results return on a single bus tagged with the requester index.
module mul_share_sched
    import mul_share_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = NUM_REQ_DEF,
    parameter  int unsigned A_BITS      = A_BITS_DEF,
    parameter  int unsigned B_BITS      = B_BITS_DEF,
    parameter  int unsigned C_BITS      = A_BITS + B_BITS,
    parameter  int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
    localparam int unsigned ID_BITS     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cke,
    input  logic [NUM_REQ-1:0]        s_valid,
    output logic [NUM_REQ-1:0]        s_ready,
    input  logic [NUM_REQ*A_BITS-1:0] s_a,
    input  logic [NUM_REQ*B_BITS-1:0] s_b,
    output logic                      m_valid,
    output logic [ID_BITS-1:0]        m_id,
    output logic [C_BITS-1:0]         m_c,
    output logic [31:0]               issue_count
);

    logic [ID_BITS-1:0] ptr_q, ptr_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [ID_BITS-1:0] grant_idx;
    logic [ID_BITS-1:0] cand;
    logic               grant_found;
    logic               accept;
    int unsigned        ptr_int;
    req_t               issue_req;

    assign ptr_int = 32'(ptr_q);

    // First valid lane searching from ptr upward, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_BITS'((ptr_int + k) % NUM_REQ);
            if (!grant_found && s_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // One-hot ready for the granted lane; suppressed while stalled or in reset.
    always_comb begin
        s_ready = '0;
        if (cke && !reset && grant_found) begin
            s_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |(s_valid & s_ready);

    // Pointer moves just past the served lane; counter bumps once per accept.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (accept) begin
            ptr_d = (grant_idx == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_idx + ID_BITS'(1);
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Arbiter pointer and issue counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (cke) begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign issue_req.a  = s_a[grant_idx*A_BITS +: A_BITS];
    assign issue_req.b  = s_b[grant_idx*B_BITS +: B_BITS];
    assign issue_req.id = grant_idx;

    mul_share_pipe #(
        .C_BITS      (C_BITS),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_pipe (
        .clk         (clk),
        .reset       (reset),
        .cke         (cke),
        .in_valid_i  (accept),
        .in_req_i    (issue_req),
        .out_valid_o (m_valid),
        .out_id_o    (m_id),
        .out_c_o     (m_c)
    );

    assign issue_count = cnt_q;

endmodule
